deser_rx: RTL and testbench
===========================

Name: deser_rx

Overview:
- Per-port serial receiver that sits directly downstream of the xbar serial outputs (one instance per bit of the 8-bit serial output bus).
- Samples one serial line on each cycle where bit_en is high, which is the clk10-rate strobe.
- Recovers framed packets and buffers them in a small FIFO.
- Presents packets on a valid/ready interface to the scoreboard or next consumer.
- It is the inverse of the upstream ser serializer.

Parameters:
- PKT_W, 16, packet width in bits; must equal $bits(packet) from xbar_pkg.
- FIFO_DEPTH, 4, receive FIFO entries; power of two, minimum 2.
- CNT_W, 8, width of the saturating drop counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- bit_en  in  1  bit-sample strobe (clk10); one clk-cycle wide.
- serial_in  in  1  serial line; idles at 0.
- pkt_out  out  PKT_W  head-of-FIFO packet.
- pkt_valid  out  1  pkt_out holds a valid packet.
- pkt_ready  in  1  consumer accepts pkt_out when valid && ready.
- frame_err  out  1  one-cycle pulse when a bad stop bit causes a packet to be dropped.
- ovf_cnt  out  CNT_W  saturating count of packets dropped because the FIFO was full.
- ferr_cnt  out  CNT_W  saturating count of framing errors.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; FIFO empty.
  - pkt_valid=0, pkt_out=0, frame_err=0, ovf_cnt=0, ferr_cnt=0.
  - Reset asserted mid-frame discards the partial frame.
- Frame format, one bit per bit_en: start bit (1), then PKT_W data bits LSB first, then stop bit (0).
- All state changes happen only on clk edges where bit_en=1, except FIFO pop and the frame_err clear.
- FSM:
  - IDLE: when serial_in=1, go to DATA with bit counter=0.
  - DATA: shift serial_in into bit[counter] and increment. When the counter reaches PKT_W-1, go to STOP (or to PARITY if enabled).
  - STOP, serial_in=0: go to IDLE and push the assembled packet on the same edge.
  - STOP, serial_in=1: go to IDLE, drop the packet, pulse frame_err next cycle, increment ferr_cnt. That 1 is not reused as a start bit.
- Latency: the packet is written on the stop-sample edge. pkt_valid rises on the following clk cycle if the FIFO was empty.
- FIFO:
  - Registered read head with first-word fall-through; pkt_out is stable while valid && !ready.
  - Push while full and no pop: the packet is dropped and ovf_cnt increments.
  - Push while full with a simultaneous pop: the push is accepted.
  - Push and pop while empty: no bypass; the packet appears the next cycle.
  - Read and write pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
- Counters saturate at 2^CNT_W-1 and never wrap.
- pkt_ready while !pkt_valid has no effect.

Optional Feature:
- Macro DESER_PARITY_CHECK_EN.
- When defined:
  - A PARITY state follows DATA and expects even parity over the data bits plus the parity bit.
  - A mismatch drops the packet after the stop bit, pulses frame_err, and increments ferr_cnt.
  - The frame is PKT_W+3 bits. The upstream ser must be built with the same macro.
- When undefined: no PARITY state, and the frame is PKT_W+2 bits.

Decomposition:
- xbar_pkg gains:
  - rx_state_t enum {IDLE, DATA, PARITY, STOP}.
  - Constants SER_START_BIT=1'b1 and SER_STOP_BIT=1'b0, shared with ser.
  - Existing packet and ports are reused.
- One sub-module, deser_fifo, parameterised on width and depth, with ports push, din, full, pop, dout, valid.

Test Plan:
- Idle line, bit_en every 10 clk: send frame 16'hA5C3 → pkt_out=16'hA5C3, pkt_valid=1 exactly one clk after the stop-sample edge. frame_err=0, counters=0.
- Send 16'h0001 with stop bit=1 → no push, one frame_err pulse, ferr_cnt=1. The next good frame 16'hFFFF is received correctly.
- pkt_ready=0, send 6 frames 16'h0001..16'h0006 (FIFO_DEPTH=4) → FIFO holds 1..4, ovf_cnt=2. Raising ready drains 1,2,3,4 in order.
- FIFO full while a stop bit is sampled in the same cycle as a pop → the new packet is accepted, ovf_cnt is unchanged, and order is preserved.
- Assert rst=0 after 7 data bits of 16'h1234 → pkt_valid=0 immediately. After release, 16'hBEEF is received with no corruption.
- With DESER_PARITY_CHECK_EN: 16'h0003 with parity bit=1 → dropped, ferr_cnt=1. The same packet with parity bit=0 is accepted.

Source files
------------

// File: rtl/xbar_pkg.sv
// xbar_pkg: types and constants shared by the crossbar, the ser serializer
// and the deser_rx receiver.
//   packet        : 16-bit crossbar packet (dst/src/payload)
//   rx_state_t    : receiver framing FSM states
//   SER_START_BIT : line level of a frame start bit
//   SER_STOP_BIT  : line level of a frame stop bit
package xbar_pkg;

  typedef struct packed {
    logic [3:0] dst;
    logic [3:0] src;
    logic [7:0] payload;
  } packet;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam logic SER_START_BIT = 1'b1;
  localparam logic SER_STOP_BIT  = 1'b0;

endpackage

// File: rtl/deser_fifo.sv
// deser_fifo: small receive FIFO with first-word fall-through read head.
//   clk, rst : clock, asynchronous active-low reset
//   push/din : write request and data; accepted when not full or when a
//              pop happens on the same edge
//   full     : all DEPTH entries occupied
//   pop      : consume head; ignored while !valid
//   dout     : head entry (zero while empty), stable until popped
//   valid    : FIFO holds at least one entry
module deser_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when the
  // index bits are equal; pointers simply wrap.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  logic pop_ok;
  logic push_ok;

  assign valid   = (wr_ptr != rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = pop && valid;
  // When full, a same-edge pop frees the slot the write lands in.
  assign push_ok = push && (!full || pop_ok);
  assign dout    = valid ? mem[rd_ptr[AW-1:0]] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers define which
  // entries are meaningful and dout is masked while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/deser_rx.sv
// deser_rx: per-port serial receiver, the inverse of the ser serializer.
// Frame, one bit per bit_en strobe: start (1), PKT_W data bits LSB first,
// [even parity bit], stop (0). Good frames are pushed into a FIFO and
// presented on a valid/ready interface.
// Optional feature macro: DESER_PARITY_CHECK_EN adds the parity bit.
//   clk, rst   : clock, asynchronous active-low reset
//   bit_en     : one-cycle bit-sample strobe
//   serial_in  : serial line, idles at 0
//   pkt_out    : head-of-FIFO packet
//   pkt_valid  : pkt_out valid
//   pkt_ready  : consumer accepts pkt_out when valid && ready
//   frame_err  : one-cycle pulse after a frame is dropped for bad stop/parity
//   ovf_cnt    : saturating count of packets dropped on a full FIFO
//   ferr_cnt   : saturating count of framing errors
module deser_rx
  import xbar_pkg::*;
#(
  parameter int PKT_W      = $bits(packet),
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_en,
  input  logic             serial_in,
  output logic [PKT_W-1:0] pkt_out,
  output logic             pkt_valid,
  input  logic             pkt_ready,
  output logic             frame_err,
  output logic [CNT_W-1:0] ovf_cnt,
  output logic [CNT_W-1:0] ferr_cnt
);

  localparam int BW = $clog2(PKT_W);

  rx_state_t        state;
  logic [BW-1:0]    bit_cnt;
  logic [PKT_W-1:0] shift_q;

  logic stop_edge;
  logic stop_ok;
  logic push_req;
  logic fifo_full;

`ifdef DESER_PARITY_CHECK_EN
  logic par_err;
  assign stop_ok = (serial_in == SER_STOP_BIT) && !par_err;
`else
  assign stop_ok = (serial_in == SER_STOP_BIT);
`endif

  assign stop_edge = bit_en && (state == STOP);
  assign push_req  = stop_edge && stop_ok;

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples values from before the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shift_q <= '0;
`ifdef DESER_PARITY_CHECK_EN
      par_err <= 1'b0;
`endif
    end else if (bit_en) begin
      case (state)
        IDLE: begin
          if (serial_in == SER_START_BIT) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          shift_q[bit_cnt] <= serial_in;
          bit_cnt          <= bit_cnt + 1'b1;
          if (bit_cnt == BW'(PKT_W - 1)) begin
`ifdef DESER_PARITY_CHECK_EN
            state <= PARITY;
`else
            state <= STOP;
`endif
          end
        end
`ifdef DESER_PARITY_CHECK_EN
        PARITY: begin
          // Even parity: data bits plus parity bit must XOR to zero.
          par_err <= (^shift_q) ^ serial_in;
          state   <= STOP;
        end
`endif
        // A bad stop bit also returns to IDLE; that 1 is never a start bit.
        STOP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_err <= 1'b0;
      ferr_cnt  <= '0;
      ovf_cnt   <= '0;
    end else begin
      frame_err <= stop_edge && !stop_ok;
      if (stop_edge && !stop_ok && (ferr_cnt != '1))
        ferr_cnt <= ferr_cnt + 1'b1;
      if (push_req && fifo_full && !(pkt_ready && pkt_valid) && (ovf_cnt != '1))
        ovf_cnt <= ovf_cnt + 1'b1;
    end
  end

  deser_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .din   (shift_q),
    .full  (fifo_full),
    .pop   (pkt_ready),
    .dout  (pkt_out),
    .valid (pkt_valid)
  );

endmodule

// File: tb/tb_deser_rx.sv
// Directed bench for deser_rx: one task per scenario, inline comparisons.
module tb_deser_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        bit_en = 1'b0;
  logic        serial_in = 1'b0;
  logic [15:0] pkt_out;
  logic        pkt_valid;
  logic        pkt_ready = 1'b0;
  logic        frame_err;
  logic [7:0]  ovf_cnt;
  logic [7:0]  ferr_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  deser_rx dut (
    .clk       (clk),
    .rst       (rst),
    .bit_en    (bit_en),
    .serial_in (serial_in),
    .pkt_out   (pkt_out),
    .pkt_valid (pkt_valid),
    .pkt_ready (pkt_ready),
    .frame_err (frame_err),
    .ovf_cnt   (ovf_cnt),
    .ferr_cnt  (ferr_cnt)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // One bit: strobe for a single clk; returns on the negedge just after
  // the sampling posedge.
  task automatic pulse_bit(input logic b);
    @(negedge clk);
    serial_in = b;
    bit_en    = 1'b1;
    @(negedge clk);
    bit_en    = 1'b0;
    serial_in = 1'b0;
  endtask

  // Pads the strobe spacing out to 10 clk.
  task automatic gap();
    repeat (8) @(negedge clk);
  endtask

  // Start bit, data bits and (if built in) parity bit; stop is separate.
  task automatic send_body(input logic [15:0] d, input logic par);
    pulse_bit(1'b1); gap();
    for (int i = 0; i < 16; i++) begin
      pulse_bit(d[i]); gap();
    end
`ifdef DESER_PARITY_CHECK_EN
    pulse_bit(par); gap();
`else
    if (par) begin end
`endif
  endtask

  // Stop bit with pkt_ready held for the same single cycle.
  task automatic send_stop(input logic stop, input logic rdy);
    @(negedge clk);
    serial_in = stop;
    bit_en    = 1'b1;
    pkt_ready = rdy;
    @(negedge clk);
    bit_en    = 1'b0;
    serial_in = 1'b0;
    pkt_ready = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] d);
    send_body(d, ^d);
    send_stop(1'b0, 1'b0);
    gap();
  endtask

  task automatic pop_one();
    @(negedge clk); pkt_ready = 1'b1;
    @(negedge clk); pkt_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++; if (pkt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", pkt_valid); end
    total++; if (pkt_out !== 16'h0) begin bad++; $display("FAIL reset_pkt got=%h exp=0000", pkt_out); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
    total++; if (ovf_cnt !== 8'd0 || ferr_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", ovf_cnt, ferr_cnt); end
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_basic();
    send_body(16'hA5C3, ^16'hA5C3);
    @(negedge clk);
    serial_in = 1'b0;
    bit_en    = 1'b1;
    total++; if (pkt_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_early got=%b exp=0", pkt_valid); end
    @(negedge clk);
    bit_en = 1'b0;
    total++; if (pkt_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", pkt_valid); end
    total++; if (pkt_out !== 16'hA5C3) begin bad++; $display("FAIL basic_data got=%h exp=a5c3", pkt_out); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL basic_ferr got=%b exp=0", frame_err); end
    total++; if (ovf_cnt !== 8'd0 || ferr_cnt !== 8'd0) begin bad++; $display("FAIL basic_cnt got=%0d/%0d exp=0/0", ovf_cnt, ferr_cnt); end
    gap();
    pop_one();
    total++; if (pkt_valid !== 1'b0) begin bad++; $display("FAIL basic_drained got=%b exp=0", pkt_valid); end
  endtask

  task automatic test_frame_err();
    send_body(16'h0001, 1'b1);
    send_stop(1'b1, 1'b0);
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL ferr_pulse got=%b exp=1", frame_err); end
    total++; if (pkt_valid !== 1'b0) begin bad++; $display("FAIL ferr_nopush got=%b exp=0", pkt_valid); end
    @(negedge clk);
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL ferr_width got=%b exp=0", frame_err); end
    total++; if (ferr_cnt !== 8'd1) begin bad++; $display("FAIL ferr_cnt got=%0d exp=1", ferr_cnt); end
    gap();
    send_frame(16'hFFFF);
    total++; if (pkt_valid !== 1'b1 || pkt_out !== 16'hFFFF) begin bad++; $display("FAIL ferr_next got=%b/%h exp=1/ffff", pkt_valid, pkt_out); end
    pop_one();
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 6; i++) send_frame(16'(i));
    total++; if (ovf_cnt !== 8'd2) begin bad++; $display("FAIL ovf_cnt got=%0d exp=2", ovf_cnt); end
    for (int k = 1; k <= 4; k++) begin
      total++; if (pkt_valid !== 1'b1 || pkt_out !== 16'(k)) begin bad++; $display("FAIL ovf_drain%0d got=%b/%h exp=1/%h", k, pkt_valid, pkt_out, 16'(k)); end
      pop_one();
    end
    total++; if (pkt_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty got=%b exp=0", pkt_valid); end
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 4; i++) send_frame(16'h0011 + 16'(i));
    total++; if (ovf_cnt !== 8'd2) begin bad++; $display("FAIL fp_fill_ovf got=%0d exp=2", ovf_cnt); end
    send_body(16'h0015, ^16'h0015);
    send_stop(1'b0, 1'b1);
    total++; if (ovf_cnt !== 8'd2) begin bad++; $display("FAIL fp_ovf got=%0d exp=2", ovf_cnt); end
    for (int k = 0; k < 4; k++) begin
      total++; if (pkt_valid !== 1'b1 || pkt_out !== 16'h0012 + 16'(k)) begin bad++; $display("FAIL fp_drain%0d got=%b/%h exp=1/%h", k, pkt_valid, pkt_out, 16'h0012 + 16'(k)); end
      pop_one();
    end
    total++; if (pkt_valid !== 1'b0) begin bad++; $display("FAIL fp_empty got=%b exp=0", pkt_valid); end
  endtask

  task automatic test_rst_mid();
    logic [15:0] d;
    d = 16'h1234;
    send_frame(16'h0042);
    pulse_bit(1'b1); gap();
    for (int i = 0; i < 7; i++) begin
      pulse_bit(d[i]); gap();
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (pkt_valid !== 1'b0 || pkt_out !== 16'h0) begin bad++; $display("FAIL rst_mid_out got=%b/%h exp=0/0000", pkt_valid, pkt_out); end
    total++; if (ovf_cnt !== 8'd0 || ferr_cnt !== 8'd0) begin bad++; $display("FAIL rst_mid_cnt got=%0d/%0d exp=0/0", ovf_cnt, ferr_cnt); end
    @(negedge clk);
    rst = 1'b1;
    gap();
    send_frame(16'hBEEF);
    total++; if (pkt_valid !== 1'b1 || pkt_out !== 16'hBEEF) begin bad++; $display("FAIL rst_mid_next got=%b/%h exp=1/beef", pkt_valid, pkt_out); end
    pop_one();
    total++; if (pkt_valid !== 1'b0 || ferr_cnt !== 8'd0) begin bad++; $display("FAIL rst_mid_clean got=%b/%0d exp=0/0", pkt_valid, ferr_cnt); end
  endtask

`ifdef DESER_PARITY_CHECK_EN
  task automatic test_parity();
    send_body(16'h0003, 1'b1);
    send_stop(1'b0, 1'b0);
    total++; if (frame_err !== 1'b1 || pkt_valid !== 1'b0) begin bad++; $display("FAIL par_bad got=%b/%b exp=1/0", frame_err, pkt_valid); end
    gap();
    total++; if (ferr_cnt !== 8'd1) begin bad++; $display("FAIL par_cnt got=%0d exp=1", ferr_cnt); end
    send_body(16'h0003, 1'b0);
    send_stop(1'b0, 1'b0);
    total++; if (pkt_valid !== 1'b1 || pkt_out !== 16'h0003 || frame_err !== 1'b0) begin bad++; $display("FAIL par_good got=%b/%h/%b exp=1/0003/0", pkt_valid, pkt_out, frame_err); end
    gap();
    pop_one();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_frame_err();
    test_overflow();
    test_full_pop();
    test_rst_mid();
`ifdef DESER_PARITY_CHECK_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
